// File: rtl/multplr_pkg.sv
// ---------------------------------------------------------------------------
// multplr_pkg
// Shared constants for the sequential 8x8 multiplier:
//   - FSM state encoding (IDLE / MUL / DONE)
//   - operand and nibble widths
//   - number of accumulation steps and the per-step shift amount
// ---------------------------------------------------------------------------
package multplr_pkg;

    localparam int OP_W  = 8;   // operand width
    localparam int NIB_W = 4;   // width of one array-multiplier operand
    localparam int STEPS = 4;   // nibble-pair products per operation

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Left shift applied to the partial product of each step:
    // lo*lo -> 0, hi*lo -> 4, lo*hi -> 4, hi*hi -> 8.
    function automatic logic [3:0] step_shift(input logic [1:0] step);
        logic [3:0] sh;
        case (step)
            2'd0:    sh = 4'd0;
            2'd1:    sh = 4'd4;
            2'd2:    sh = 4'd4;
            default: sh = 4'd8;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/four_bit_comb_arr_multplr.sv
// ---------------------------------------------------------------------------
// four_bit_comb_arr_multplr
// Purely combinational 4x4 unsigned array multiplier.
// Ports:
//   a_i [3:0]  multiplier nibble
//   b_i [3:0]  multiplicand nibble
//   p_o [7:0]  unsigned product a_i * b_i
// ---------------------------------------------------------------------------
module four_bit_comb_arr_multplr
    import multplr_pkg::*;
(
    input  logic [NIB_W-1:0]   a_i,
    input  logic [NIB_W-1:0]   b_i,
    output logic [2*NIB_W-1:0] p_o
);

    // One AND row per multiplicand bit, each row offset by its bit position,
    // summed down the array.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        p_o = '0;
        for (int i = 0; i < NIB_W; i++) begin
            p_o = p_o + ({{NIB_W{1'b0}}, a_i & {NIB_W{b_i[i]}}} << i);
        end
    end

endmodule

// File: rtl/eight_bit_seq_arr_multplr.sv
// ---------------------------------------------------------------------------
// eight_bit_seq_arr_multplr
// Sequential 8x8 unsigned multiplier that reuses one 4x4 array multiplier
// over four cycles, shift-accumulating the nibble products into 16 bits.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand pair on a/b is valid
//   in_ready   operands accepted (IDLE only, low during reset)
//   a, b       8-bit unsigned operands
//   out_valid  product holds a finished result (DONE)
//   out_ready  consumer takes the result
//   product    registered 16-bit accumulator / result
// ---------------------------------------------------------------------------
module eight_bit_seq_arr_multplr
    import multplr_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     product
);

    logic [1:0]         state_q, state_d;
    logic [1:0]         step_q,  step_d;
    logic [OP_W-1:0]    a_q,     a_d;
    logic [OP_W-1:0]    b_q,     b_d;
    logic [15:0]        acc_q,   acc_d;

    logic [NIB_W-1:0]   nib_a;
    logic [NIB_W-1:0]   nib_b;
    logic [2*NIB_W-1:0] pp;

    // Step bit 0 picks the high nibble of a, step bit 1 the high nibble of b,
    // giving the order lo*lo, hi*lo, lo*hi, hi*hi.
    always_comb begin
        nib_a = step_q[0] ? a_q[OP_W-1:NIB_W] : a_q[NIB_W-1:0];
        nib_b = step_q[1] ? b_q[OP_W-1:NIB_W] : b_q[NIB_W-1:0];
    end

    four_bit_comb_arr_multplr u_arr (
        .a_i (nib_a),
        .b_i (nib_b),
        .p_o (pp)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                // pp is zero-extended before the shift; 255*255 fits in 16 bits.
                acc_d  = acc_q + ({8'h00, pp} << step_shift(step_q));
                step_d = step_q + 2'd1;
                if (step_q == 2'(STEPS - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value regardless of statement order.
        if (rst) begin
            // NOTE: the operand registers are reset along with the control
            // state; they are only read in MUL, so this just keeps them tidy.
            state_q <= ST_IDLE;
            step_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    // in_ready is gated by rst so nothing is offered while reset is applied.
    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign product   = acc_q;

endmodule

// File: tb/tb_eight_bit_seq_arr_multplr.sv
// ---------------------------------------------------------------------------
// tb_eight_bit_seq_arr_multplr
// Directed and randomized checks of the sequential 8x8 multiplier against an
// arithmetic reference (nibble-product partial sums and the plain a*b).
// ---------------------------------------------------------------------------
module tb_eight_bit_seq_arr_multplr;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;

    int checks = 0;
    int errors = 0;

    eight_bit_seq_arr_multplr dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Running sum after k+1 steps, built from the nibble-product ordering
    // lo*lo, hi*lo (x16), lo*hi (x16), hi*hi (x256).
    function automatic logic [15:0] ref_partial(input logic [7:0] x, input logic [7:0] y, input int k);
        int terms [4];
        int sum;
        terms[0] = (x % 16) * (y % 16);
        terms[1] = (x / 16) * (y % 16) * 16;
        terms[2] = (x % 16) * (y / 16) * 16;
        terms[3] = (x / 16) * (y / 16) * 256;
        sum = 0;
        for (int i = 0; i <= k; i++) sum += terms[i];
        return 16'(sum);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_timeout", {15'd0, in_ready}, 16'd1);
    endtask

    // Accept one operand pair and follow it through all four accumulation
    // edges; leaves the DUT in DONE with out_valid high.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input string tag);
        logic [15:0] full;
        full = 16'(int'(ta) * int'(tb));
        wait_ready();
        in_valid = 1'b1;
        a = ta;
        b = tb;
        tick();                         // accept edge
        in_valid = 1'b0;
        a = 8'($urandom);               // must be ignored from here on
        b = 8'($urandom);
        check({tag, "_acc_clear"}, product, 16'h0000);
        check({tag, "_busy_ready"}, {15'd0, in_ready}, 16'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("%s_step%0d", tag, k), product, ref_partial(ta, tb, k));
            check($sformatf("%s_valid%0d", tag, k), {15'd0, out_valid}, (k == 3) ? 16'd1 : 16'd0);
        end
        check({tag, "_product"}, product, full);
    endtask

    // Handshake edge with out_ready high: IDLE and ready the following cycle.
    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        check({tag, "_drain_valid"}, {15'd0, out_valid}, 16'd0);
        check({tag, "_drain_ready"}, {15'd0, in_ready}, 16'd1);
    endtask

    initial begin
        logic [7:0]  ra, rb;
        logic [15:0] held;
        int          hold;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        out_ready = 1'b1;

        // Reset release
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ready", {15'd0, in_ready}, 16'd0);
            check("rst_valid", {15'd0, out_valid}, 16'd0);
            check("rst_product", product, 16'h0000);
        end
        rst = 1'b0;
        #1;
        check("post_rst_ready", {15'd0, in_ready}, 16'd1);
        check("post_rst_valid", {15'd0, out_valid}, 16'd0);
        check("post_rst_product", product, 16'h0000);

        // Worked example: partials 0x0008, 0x0048, 0x00A8, 0x03A8
        run_op(8'h12, 8'h34, "ex");
        check("ex_literal", product, 16'h03A8);
        drain("ex");

        // Full-scale and corner operands back to back (6-cycle spacing)
        run_op(8'hFF, 8'hFF, "ffff");
        check("ffff_literal", product, 16'hFE01);
        drain("ffff");
        run_op(8'h00, 8'hAB, "zero");
        check("zero_literal", product, 16'h0000);
        drain("zero");
        run_op(8'h01, 8'h01, "one");
        check("one_literal", product, 16'h0001);
        drain("one");

        // Backpressure with a pending operand pair
        out_ready = 1'b0;
        run_op(8'h9C, 8'h3D, "bp");
        held = product;
        in_valid = 1'b1;
        a = 8'h0F;
        b = 8'h0F;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", {15'd0, out_valid}, 16'd1);
            check("bp_hold_product", product, 16'(int'(8'h9C) * int'(8'h3D)));
            check("bp_hold_ready", {15'd0, in_ready}, 16'd0);
        end
        check("bp_held_same", product, held);
        drain("bp");
        run_op(8'h0F, 8'h0F, "pend");
        check("pend_literal", product, 16'h00E1);
        drain("pend");

        // Mid-operation reset at step 2
        wait_ready();
        in_valid = 1'b1;
        a = 8'hA5;
        b = 8'h5A;
        tick();                         // accept
        in_valid = 1'b0;
        tick();                         // step 0 done
        tick();                         // step 1 done, now in step 2
        rst = 1'b1;
        tick();
        check("mid_rst_valid", {15'd0, out_valid}, 16'd0);
        check("mid_rst_acc", product, 16'h0000);
        check("mid_rst_ready_low", {15'd0, in_ready}, 16'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_ready", {15'd0, in_ready}, 16'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mid_rst_no_stale_valid", {15'd0, out_valid}, 16'd0);
            check("mid_rst_no_stale_product", product, 16'h0000);
        end
        run_op(8'h03, 8'h07, "fresh");
        check("fresh_literal", product, 16'h0015);
        drain("fresh");

        // Randomized operands with random consumer stall
        for (int n = 0; n < 12; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            out_ready = 1'b0;
            run_op(ra, rb, "rnd");
            hold = int'($urandom_range(0, 3));
            for (int i = 0; i < hold; i++) begin
                tick();
                check("rnd_stall_product", product, 16'(int'(ra) * int'(rb)));
                check("rnd_stall_valid", {15'd0, out_valid}, 16'd1);
            end
            drain("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
